// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, opcode and branch funct3 constants
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_op_t arith_op(logic [2:0] funct3, logic alt);
    case (funct3)
      3'b000: begin
        if (alt) return ALU_SUB;
        return ALU_ADD;
      end
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: begin
        if (alt) return ALU_SRA;
        return ALU_SRL;
      end
      3'b110: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps opcode/funct3/funct7b5 to ALU op, SrcB select and flags
// Branch decode exists only when ALU_BRANCH_EVAL_EN is defined.
module alu_decoder (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op,
  output logic       src_b_imm,
  output logic       illegal,
  output logic       is_branch
);
  import alu_pkg::*;

  always_comb begin
    alu_op    = ALU_ADD;
    src_b_imm = 1'b1;
    illegal   = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op    = arith_op(funct3, funct7b5);
        src_b_imm = 1'b0;
      end
      // immediate form has no SUBI, so bit 30 only matters for shifts
      OP_I: alu_op = arith_op(funct3, funct7b5 && (funct3 != 3'b000));
      OP_LOAD, OP_STORE: alu_op = ALU_ADD;
`ifdef ALU_BRANCH_EVAL_EN
      OP_BRANCH: begin
        src_b_imm = 1'b0;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          illegal = 1'b1;
        end else begin
          alu_op    = ALU_SUB;
          is_branch = 1'b1;
        end
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-stage issue/retire controller for the integer ALU
// Branch resolution is built only when ALU_BRANCH_EVAL_EN is defined.
module alu_issue_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [6:0]      Opcode,
  input  logic [2:0]      Funct3,
  input  logic            Funct7b5,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [4:0]      RdIn,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            Zero,
  input  logic            LessS,
  input  logic            LessU,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic [4:0]      RdOut,
  output logic            Illegal,
  output logic            IsBranch,
  output logic            BranchTaken
);
  import alu_pkg::*;

  logic       iss_v, out_v, advance;
  logic [4:0] iss_rd;
  logic       iss_illegal;
  logic [3:0] dec_op;
  logic       dec_imm, dec_illegal, dec_branch;

  alu_decoder u_dec (
    .opcode    (Opcode),
    .funct3    (Funct3),
    .funct7b5  (Funct7b5),
    .alu_op    (dec_op),
    .src_b_imm (dec_imm),
    .illegal   (dec_illegal),
    .is_branch (dec_branch)
  );

  // the issue stage may refill in the same cycle the output stage drains
  assign advance  = !out_v || OutReady;
  assign InReady  = !iss_v || advance;
  assign OutValid = out_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_v       <= 1'b0;
      SrcA        <= '0;
      SrcB        <= '0;
      ALUControl  <= '0;
      iss_rd      <= '0;
      iss_illegal <= 1'b0;
    end else if (Flush) begin
      iss_v <= 1'b0;
    end else if (InReady) begin
      iss_v <= InValid;
      if (InValid) begin
        SrcA        <= RD1;
        SrcB        <= dec_imm ? ImmExt : RD2;
        ALUControl  <= dec_op;
        iss_rd      <= RdIn;
        iss_illegal <= dec_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_v   <= 1'b0;
      Result  <= '0;
      RdOut   <= '0;
      Illegal <= 1'b0;
    end else if (Flush) begin
      out_v <= 1'b0;
    end else if (advance) begin
      out_v <= iss_v;
      if (iss_v) begin
        Result  <= iss_illegal ? '0 : ALUResult;
        RdOut   <= iss_rd;
        Illegal <= iss_illegal;
      end
    end
  end

`ifdef ALU_BRANCH_EVAL_EN
  logic [2:0] iss_funct3;
  logic       iss_branch, taken;

  always_comb begin
    taken = 1'b0;
    case (iss_funct3)
      F3_BEQ:  taken = Zero;
      F3_BNE:  taken = !Zero;
      F3_BLT:  taken = LessS;
      F3_BGE:  taken = !LessS;
      F3_BLTU: taken = LessU;
      F3_BGEU: taken = !LessU;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_funct3 <= '0;
      iss_branch <= 1'b0;
    end else if (!Flush && InValid && InReady) begin
      iss_funct3 <= Funct3;
      iss_branch <= dec_branch;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IsBranch    <= 1'b0;
      BranchTaken <= 1'b0;
    end else if (!Flush && advance && iss_v) begin
      IsBranch    <= iss_branch;
      BranchTaken <= iss_branch && taken;
    end
  end
`else
  logic unused_branch;
  assign unused_branch = ^{Zero, LessS, LessU, dec_branch};
  assign IsBranch      = 1'b0;
  assign BranchTaken   = 1'b0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Two-stage issue/retire controller for the 32-bit integer ALU in the RISC-V MMIO core. It accepts decoded instruction fields and operands over a valid/ready handshake, translates opcode/funct3/funct7 into the ALU's 4-bit operation code, and registers the operands that drive the ALU. It then captures the ALU result and flags into an output register and, when enabled, resolves conditional branches from the Zero/LessS/LessU flags. Sustains one operation per cycle under back-pressure.

## Interface
- XLEN, 32, datapath width; only 32 is legal.
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Flush  in  1  synchronous kill of both stages
- InValid  in  1  input beat valid
- InReady  out  1  controller can accept a beat
- Opcode  in  7  instruction opcode
- Funct3  in  3  instruction funct3
- Funct7b5  in  1  instruction bit 30
- RD1, RD2  in  32  register operands
- ImmExt  in  32  sign-extended immediate
- RdIn  in  5  destination register
- SrcA, SrcB  out  32  ALU operands (registered)
- ALUControl  out  4  ALU operation (registered)
- ALUResult  in  32  ALU result
- Zero, LessS, LessU  in  1  ALU flags
- OutValid  out  1  result beat valid
- OutReady  in  1  consumer accepts result
- Result  out  32  captured ALUResult
- RdOut  out  5  destination register
- Illegal  out  1  unsupported encoding
- IsBranch  out  1  beat is a conditional branch
- BranchTaken  out  1  branch condition true

## Operation
- Op codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- Opcode 0110011 (R): SrcB=RD2; funct3 000 ADD/SUB (SUB when Funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when Funct7b5), 110 OR, 111 AND.
- Opcode 0010011 (I): SrcB=ImmExt; same map, except funct3 000 is always ADD.
- Opcodes 0000011/0100011 (load/store): ADD, SrcB=ImmExt.
- Opcode 1100011 (branch, macro enabled): SUB, SrcB=RD2; BEQ 000 Zero, BNE 001 !Zero, BLT 100 LessS, BGE 101 !LessS, BLTU 110 LessU, BGEU 111 !LessU; funct3 010/011 are illegal.
- Any other encoding: Illegal=1, ALUControl=ADD, captured Result forced to 0, IsBranch=0.
- SrcA=RD1 in all cases.
- Stage valids: iss_v (issue register), out_v (= OutValid).
- advance = !out_v || OutReady; InReady = !iss_v || advance.
- Input beat accepted when InValid && InReady.
- Output register loads when iss_v && advance; out_v clears on OutReady with no new load.
- Output fields are held stable while OutValid && !OutReady.

## Timing
- Reset (async assert): iss_v=0, out_v=0, SrcA=SrcB=0, ALUControl=0000, Result=0, RdOut=0, Illegal=IsBranch=BranchTaken=0. InReady is 1 one cycle after deassertion.
- Latency: beat accepted at edge N; ALU driven during cycle N+1; OutValid high from edge N+1 through N+2 onward.
- Throughput: 1 beat/cycle with OutReady held high.
- Full (iss_v && out_v && !OutReady): InReady=0; no state changes.
- Simultaneous OutReady and load: the old result retires and the new one loads on the same edge.
- Flush: on the next edge iss_v=0 and out_v=0. Flush has priority over a same-cycle accept, which is dropped. Data registers need not clear.
- InReady depends combinationally on OutReady; no other input-to-output combinational path.

## Configuration
- ALU_BRANCH_EVAL_EN defined: branch opcode decoded as above; IsBranch and BranchTaken registered with the result.
- Not defined: opcode 1100011 is Illegal; IsBranch and BranchTaken are tied to 0; no flag logic is synthesized.

## Structure
- Package alu_pkg:
  - alu_op_t enum (4-bit codes above)
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - branch funct3 localparams
- Combinational sub-module alu_decoder maps Opcode/Funct3/Funct7b5 to alu_op_t, SrcB select, Illegal, IsBranch.
- alu_issue_ctrl holds both pipeline registers and the handshake.

## Test plan
- R SUB, RD1=5, RD2=7, Funct7b5=1, OutReady=1: ALUControl=0011; Result=0xFFFFFFFE two edges after accept.
- I SRAI, RD1=0x80000000, ImmExt=4, Funct7b5=1: ALUControl=0111; Result=0xF8000000.
- BLTU, RD1=1, RD2=0xFFFFFFFF (macro on): IsBranch=1, BranchTaken=1. Same beat with macro off: Illegal=1, Result=0.
- Three back-to-back beats, OutReady low for 3 cycles: InReady drops after the 2nd accept; results retire in order with no loss or duplication.
- Flush asserted in the same cycle as an accept, with one beat in the issue register: OutValid never rises for either beat; InReady=1 the next cycle.
- reset_n pulsed low mid-stream: all outputs zero asynchronously; first beat after release retires after the standard 2-edge latency.
